// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin write arbiter with lockable tenure over one shared WIDTH-bit register
module dff_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  parameter int MAX_HOLD = 8,
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int HW = $clog2(MAX_HOLD + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic [OW-1:0]         owner,
  output logic                  busy
);
  typedef enum logic {IDLE, OWNED} state_t;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);
  state_t state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d, ack_q, ack_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [OW-1:0] owner_q, owner_d, rr_q, rr_d, win, idx;
  logic [HW-1:0] hold_q, hold_d;
  logic found, rel, idle;
  function automatic logic [OW-1:0] nxt(input logic [OW-1:0] x);
    return (int'(x) == NREQ - 1) ? '0 : x + 1'b1;
  endfunction
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = OW'((int'(rr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
    idle = state_q == IDLE;
    rel = !lock[owner_q] || hold_q == HW'(MAX_HOLD);
    state_d = idle ? ((found && lock[win]) ? OWNED : IDLE) : (rel ? IDLE : OWNED);
    grant_d = idle ? (found ? ONE << win : '0) : (rel ? '0 : ONE << owner_q);
    ack_d = idle ? (found ? ONE << win : '0) : ((rel || !req[owner_q]) ? '0 : ONE << owner_q);
    q_d = (idle && found) ? wdata[win*WIDTH +: WIDTH] :
          (!idle && !rel && req[owner_q]) ? wdata[owner_q*WIDTH +: WIDTH] : q_q;
    owner_d = (idle && found) ? win : owner_q;
    hold_d = idle ? HW'(1) : hold_q + 1'b1;
    rr_d = idle ? ((found && !lock[win]) ? nxt(win) : rr_q) : (rel ? nxt(owner_q) : rr_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q <= '0;
      q_q <= '0;
      owner_q <= '0;
      rr_q <= '0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q <= ack_d;
      q_q <= q_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      hold_q <= hold_d;
    end
  end
  assign grant = grant_q;
  assign ack = ack_q;
  assign q = q_q;
  assign owner = owner_q;
  assign busy = state_q == OWNED;
endmodule
